// File: rtl/jpeg_strip_if.sv
// jpeg_strip_if: pixel input, two-bank strip buffer write/read ports and block handshake
interface jpeg_strip_if #(parameter int ADDR_W = 9);
   logic              pix_valid, pix_ready;
   logic              wr_en, wr_bank;
   logic [ADDR_W-1:0] wr_addr;
   logic              blk_ready;
   logic              rd_en, rd_bank, rd_first, rd_last;
   logic [ADDR_W-1:0] rd_addr;
   modport master (
      input  pix_valid, blk_ready,
      output pix_ready, wr_en, wr_bank, wr_addr, rd_en, rd_bank, rd_addr, rd_first, rd_last
   );
   modport slave (
      output pix_valid, blk_ready,
      input  pix_ready, wr_en, wr_bank, wr_addr, rd_en, rd_bank, rd_addr, rd_first, rd_last
   );
endinterface

// File: rtl/jpeg_strip_ctrl.sv
// jpeg_strip_ctrl: writes raster pixels into 8-row strip banks and replays each full bank as 8x8 blocks
module jpeg_strip_ctrl #(
   parameter int IMG_WIDTH  = 64,
   parameter int IMG_HEIGHT = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              img_done,
   jpeg_strip_if.master      bus
);
   localparam int ADDR_W = $clog2(8*IMG_WIDTH);
   localparam int STRIP  = 8*IMG_WIDTH;
   localparam int TOTAL  = IMG_WIDTH*IMG_HEIGHT;
   localparam int NBX    = IMG_WIDTH/8;
   localparam int NSTRIP = IMG_HEIGHT/8;
   localparam int CW     = $clog2(TOTAL+1);
   localparam int BXW    = NBX > 1 ? $clog2(NBX) : 1;
   localparam int SW     = NSTRIP > 1 ? $clog2(NSTRIP) : 1;
   if (IMG_WIDTH % 8 != 0 || IMG_HEIGHT % 8 != 0) begin : g_bad_size
      $error("jpeg_strip_ctrl: IMG_WIDTH and IMG_HEIGHT must be multiples of 8");
   end
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_READ, R_NEXT} rstate_t;
   rstate_t           state, state_n;
   logic [ADDR_W-1:0] wa, rd_addr_c;
   logic [CW-1:0]     pix_cnt;
   logic              wsel, wr_end, go, xfer, wlast, blk_end, bf_clr, frame_end;
   logic [1:0]        bank_full, set_m, clr_m;
   logic [5:0]        smp;
   logic [BXW-1:0]    bx;
   logic [SW-1:0]     rstrip;
   // wsel is the bank the next accepted pixel lands in; it flips on acceptance, ahead of wr_bank
   assign go        = start & ~busy;
   assign bus.pix_ready = busy & ~bank_full[wsel] & (pix_cnt < CW'(TOTAL));
   assign xfer      = bus.pix_valid & bus.pix_ready;
   assign wlast     = wa == ADDR_W'(STRIP-1);
   assign blk_end   = bx == BXW'(NBX-1);
   assign set_m     = {bus.wr_bank, ~bus.wr_bank} & {2{bus.wr_en & wr_end}};
   assign clr_m     = {bus.rd_bank, ~bus.rd_bank} & {2{bf_clr}};
   assign rd_addr_c = ADDR_W'(smp[5:3]) * ADDR_W'(IMG_WIDTH) + ADDR_W'({bx, 3'b000}) + ADDR_W'(smp[2:0]);
   assert property (@(posedge clk) disable iff (!rst_n) (set_m & clr_m) == 2'b00);
   always_comb begin
      state_n   = state;
      bf_clr    = 1'b0;
      frame_end = 1'b0;
      case (state)
         R_IDLE: state_n = bank_full[bus.rd_bank] ? R_WAIT : R_IDLE;
         R_WAIT: state_n = bus.blk_ready ? R_READ : R_WAIT;
         R_READ: state_n = &smp ? R_NEXT : R_READ;
         R_NEXT: begin
            state_n   = blk_end ? R_IDLE : R_WAIT;
            bf_clr    = blk_end;
            frame_end = blk_end & (rstrip == SW'(NSTRIP-1));
         end
         default: state_n = R_IDLE;
      endcase
      if (go) state_n = R_IDLE;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= R_IDLE;
      else        state <= state_n;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy         <= 1'b0;
         img_done     <= 1'b0;
         wa           <= '0;
         pix_cnt      <= '0;
         wsel         <= 1'b0;
         wr_end       <= 1'b0;
         bank_full    <= '0;
         smp          <= '0;
         bx           <= '0;
         rstrip       <= '0;
         bus.wr_en    <= 1'b0;
         bus.wr_bank  <= 1'b0;
         bus.wr_addr  <= '0;
         bus.rd_en    <= 1'b0;
         bus.rd_bank  <= 1'b0;
         bus.rd_addr  <= '0;
         bus.rd_first <= 1'b0;
         bus.rd_last  <= 1'b0;
      end else if (go) begin
         busy         <= 1'b1;
         img_done     <= 1'b0;
         wa           <= '0;
         pix_cnt      <= '0;
         wsel         <= 1'b0;
         wr_end       <= 1'b0;
         bank_full    <= '0;
         smp          <= '0;
         bx           <= '0;
         rstrip       <= '0;
         bus.wr_en    <= 1'b0;
         bus.wr_bank  <= 1'b0;
         bus.wr_addr  <= '0;
         bus.rd_en    <= 1'b0;
         bus.rd_bank  <= 1'b0;
         bus.rd_addr  <= '0;
         bus.rd_first <= 1'b0;
         bus.rd_last  <= 1'b0;
      end else begin
         busy         <= busy & ~frame_end;
         img_done     <= frame_end;
         bus.wr_en    <= xfer;
         wr_end       <= xfer & wlast;
         if (xfer) begin
            bus.wr_addr <= wa;
            wa          <= wlast ? '0 : wa + 1'b1;
            pix_cnt     <= pix_cnt + 1'b1;
            wsel        <= wsel ^ wlast;
         end
         bus.wr_bank  <= xfer ? wsel : bus.wr_bank ^ (bus.wr_en & wr_end);
         bank_full    <= (bank_full | set_m) & ~clr_m;
         bus.rd_en    <= state == R_READ;
         bus.rd_first <= state == R_READ && smp == 6'd0;
         bus.rd_last  <= state == R_READ && &smp;
         if (state == R_READ) bus.rd_addr <= rd_addr_c;
         smp          <= state == R_READ ? smp + 1'b1 : '0;
         if (state == R_NEXT) begin
            bx     <= blk_end ? '0 : bx + 1'b1;
            rstrip <= rstrip + SW'(blk_end);
         end
         bus.rd_bank  <= bus.rd_bank ^ bf_clr;
      end
   end
endmodule
